// File: rtl/baccarat_pkg.sv
// Shared types and helpers for the baccarat round sequencer.
package baccarat_pkg;

  // Round sequencer states, listed in deal order.
  typedef enum logic [3:0] {
    DEAL_P1,
    DEAL_D1,
    DEAL_P2,
    DEAL_D2,
    EVAL_NAT,
    DEAL_P3,
    EVAL_D3,
    EVAL_D,
    DEAL_D3,
    RESULT,
    DONE
  } state_t;

  // When the player stood, the dealer stands at this total or above.
  localparam logic [3:0] DEALER_STAND_NO_P3 = 4'd6;

  // Card rank 1..13 to baccarat point value 0..9 (tens and faces count as 0).
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    return (rank >= 4'd10) ? 4'd0 : rank;
  endfunction

  // Scores above 9 never come from scorehand; treat them as 9 so they compare high and stand.
  function automatic logic [3:0] clamp_score(input logic [3:0] score);
    return (score > 4'd9) ? 4'd9 : score;
  endfunction

endpackage

// File: rtl/baccarat_ctrl_if.sv
// Signal bundle between the round sequencer and the datapath/scorehand side.
interface baccarat_ctrl_if;
  logic       step;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic       player_win_light;
  logic       dealer_win_light;
  logic       round_done;

  // Datapath side: supplies step and scores, receives strobes and lights.
  modport master (
    output step, pscore, dscore, pcard3,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light, round_done
  );

  // Sequencer side.
  modport slave (
    input  step, pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light, round_done
  );
endinterface

// File: rtl/dealer_draw_rule.sv
// Dealer third-card rule when the player has drawn a third card.
module dealer_draw_rule (
  input  logic [3:0] dscore,  // dealer two-card total, already clamped to 0..9
  input  logic [3:0] pvalue,  // player third-card point value 0..9
  output logic       draw
);

  // Tableau lookup on dealer total and player third-card value.
  always_comb begin
    // NOTE: default first so every path assigns draw and no latch is inferred.
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (pvalue != 4'd8);
      4'd4:             draw = (pvalue >= 4'd2) && (pvalue <= 4'd7);
      4'd5:             draw = (pvalue >= 4'd4) && (pvalue <= 4'd7);
      4'd6:             draw = (pvalue == 4'd6) || (pvalue == 4'd7);
      default:          draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_ctrl.sv
// Baccarat round sequencer: deal strobes, third-card rules, winner lights.
module baccarat_ctrl
  import baccarat_pkg::*;
#(
  parameter int NATURAL_MIN  = 8,
  parameter int PLAYER_STAND = 6
) (
  input  logic           slow_clock,
  input  logic           resetb,
  baccarat_ctrl_if.slave bus
);

  localparam logic [3:0] NAT_MIN_4   = 4'(NATURAL_MIN);
  localparam logic [3:0] P_STAND_4   = 4'(PLAYER_STAND);

  state_t     state;
  state_t     state_next;
  logic [3:0] pscore_c;
  logic [3:0] dscore_c;
  logic [3:0] pvalue;
  logic       d3_draw;
  logic       player_light;
  logic       dealer_light;
  logic [5:0] strobes;

  assign pscore_c = clamp_score(bus.pscore);
  assign dscore_c = clamp_score(bus.dscore);
  assign pvalue   = card_value(bus.pcard3);

  dealer_draw_rule u_draw_rule (
    .dscore (dscore_c),
    .pvalue (pvalue),
    .draw   (d3_draw)
  );

  // State register.
  always_ff @(posedge slow_clock or negedge resetb) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!resetb) state <= DEAL_P1;
    else         state <= state_next;
  end

  // Next-state logic; every transition except DONE's self-loop is gated by step.
  always_comb begin
    state_next = state;
    if (bus.step) begin
      case (state)
        DEAL_P1:  state_next = DEAL_D1;
        DEAL_D1:  state_next = DEAL_P2;
        DEAL_P2:  state_next = DEAL_D2;
        DEAL_D2:  state_next = EVAL_NAT;
        EVAL_NAT: begin
          if (pscore_c >= NAT_MIN_4 || dscore_c >= NAT_MIN_4) state_next = RESULT;
          else if (pscore_c < P_STAND_4)                      state_next = DEAL_P3;
          else                                                state_next = EVAL_D;
        end
        DEAL_P3:  state_next = EVAL_D3;
        EVAL_D3:  state_next = d3_draw ? DEAL_D3 : RESULT;
        EVAL_D:   state_next = (dscore_c < DEALER_STAND_NO_P3) ? DEAL_D3 : RESULT;
        DEAL_D3:  state_next = RESULT;
        RESULT:   state_next = DONE;
        DONE:     state_next = DONE;
        default:  state_next = DEAL_P1;
      endcase
    end
  end

  // Mealy load strobes; gated by resetb so a strobe in flight dies with reset.
  always_comb begin
    strobes = 6'b0;
    if (resetb && bus.step) begin
      case (state)
        DEAL_P1: strobes[0] = 1'b1;
        DEAL_P2: strobes[1] = 1'b1;
        DEAL_P3: strobes[2] = 1'b1;
        DEAL_D1: strobes[3] = 1'b1;
        DEAL_D2: strobes[4] = 1'b1;
        DEAL_D3: strobes[5] = 1'b1;
        default: strobes = 6'b0;
      endcase
    end
  end

  // Winner lights latch on the edge leaving RESULT and hold until reset.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      player_light <= 1'b0;
      dealer_light <= 1'b0;
    end else if (state == RESULT && bus.step) begin
      player_light <= (pscore_c >= dscore_c);
      dealer_light <= (dscore_c >= pscore_c);
    end
  end

  assign bus.load_pcard1      = strobes[0];
  assign bus.load_pcard2      = strobes[1];
  assign bus.load_pcard3      = strobes[2];
  assign bus.load_dcard1      = strobes[3];
  assign bus.load_dcard2      = strobes[4];
  assign bus.load_dcard3      = strobes[5];
  assign bus.player_win_light = player_light;
  assign bus.dealer_win_light = dealer_light;
  assign bus.round_done       = (state == DONE);

endmodule

// File: tb/tb_baccarat_ctrl.sv
// Directed testbench for baccarat_ctrl.
module tb_baccarat_ctrl;

  logic slow_clock = 1'b0;
  logic resetb;
  int   checks = 0;
  int   errors = 0;

  baccarat_ctrl_if bus ();

  baccarat_ctrl dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .bus        (bus)
  );

  always #5 slow_clock = ~slow_clock;

  // Strobe vector, one-hot in deal order: {p1,d1,p2,d2,p3,d3}.
  function automatic logic [5:0] loads();
    return {bus.load_pcard1, bus.load_dcard1, bus.load_pcard2,
            bus.load_dcard2, bus.load_pcard3, bus.load_dcard3};
  endfunction

  task automatic apply_reset();
    bus.step = 1'b0;
    @(negedge slow_clock);
    resetb = 1'b0;
    #2;
    resetb = 1'b1;
    @(posedge slow_clock);
    #1;
  endtask

  // Plays a whole round with step mostly high; acts as scorehand by updating
  // totals after the third-card strobes. Optionally stalls after a given step count.
  task automatic play_round(input string name, input bit do_reset,
                            input logic [3:0] p2, input logic [3:0] d2, input logic [3:0] c3,
                            input logic [3:0] pf, input logic [3:0] df,
                            input bit ep3, input bit ed3, input int ecycles,
                            input bit epl, input bit edl,
                            input int stall_after, input int stall_len);
    logic [5:0] seq[$];
    logic [5:0] exp_seq[$];
    logic [5:0] l;
    int steps = 0;
    int stalled = 0;
    bit s;
    if (do_reset) apply_reset();
    bus.pscore = p2;
    bus.dscore = d2;
    bus.pcard3 = c3;
    for (int cyc = 0; cyc < 40 && !bus.round_done; cyc++) begin
      s = 1'b1;
      if (steps == stall_after && stalled < stall_len) begin
        s = 1'b0;
        stalled++;
      end
      @(negedge slow_clock);
      bus.step = s;
      #1;
      l = loads();
      if (!s) begin
        checks++;
        if (l !== 6'b0) begin
          errors++;
          $display("FAIL %s stall_strobe: got %b want 000000", name, l);
        end
      end
      if ($countones(l) > 1) begin
        errors++;
        $display("FAIL %s multi_strobe: got %b", name, l);
      end
      if (l != 6'b0) seq.push_back(l);
      @(posedge slow_clock);
      #1;
      if (s) steps++;
      if (l[1]) bus.pscore = pf;
      if (l[0]) bus.dscore = df;
    end
    bus.step = 1'b0;
    exp_seq = '{6'b100000, 6'b010000, 6'b001000, 6'b000100};
    if (ep3) exp_seq.push_back(6'b000010);
    if (ed3) exp_seq.push_back(6'b000001);

    checks++;
    if (bus.round_done !== 1'b1) begin
      errors++;
      $display("FAIL %s round_done: got %b want 1 (timeout)", name, bus.round_done);
    end
    checks++;
    if (steps != ecycles) begin
      errors++;
      $display("FAIL %s step_cycles: got %0d want %0d", name, steps, ecycles);
    end
    checks++;
    if (seq.size() != exp_seq.size()) begin
      errors++;
      $display("FAIL %s strobe_count: got %0d want %0d", name, seq.size(), exp_seq.size());
    end else begin
      for (int i = 0; i < seq.size(); i++) begin
        if (seq[i] !== exp_seq[i]) begin
          errors++;
          $display("FAIL %s strobe_order[%0d]: got %b want %b", name, i, seq[i], exp_seq[i]);
        end
      end
    end
    checks++;
    if ({bus.player_win_light, bus.dealer_win_light} !== {epl, edl}) begin
      errors++;
      $display("FAIL %s lights: got p=%b d=%b want p=%b d=%b", name,
               bus.player_win_light, bus.dealer_win_light, epl, edl);
    end
  endtask

  task automatic test_reset();
    bus.step = 1'b1;
    bus.pscore = 4'd0;
    bus.dscore = 4'd0;
    bus.pcard3 = 4'd1;
    resetb = 1'b0;
    #3;
    checks++;
    if (loads() !== 6'b0 || bus.player_win_light !== 1'b0 ||
        bus.dealer_win_light !== 1'b0 || bus.round_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got loads=%b p=%b d=%b done=%b want all 0", loads(),
               bus.player_win_light, bus.dealer_win_light, bus.round_done);
    end
    @(negedge slow_clock);
    bus.step = 1'b0;
    resetb = 1'b1;
    @(posedge slow_clock);
    #1;
  endtask

  task automatic test_natural();
    play_round("natural", 1'b1, 4'd8, 4'd5, 4'd3, 4'd8, 4'd5, 1'b0, 1'b0, 6, 1'b1, 1'b0, -1, 0);
  endtask

  task automatic test_player_draws();
    play_round("p_draw_d7", 1'b1, 4'd3, 4'd7, 4'd8, 4'd1, 4'd7, 1'b1, 1'b0, 8, 1'b0, 1'b1, -1, 0);
  endtask

  task automatic test_dealer_six();
    play_round("d6_face", 1'b1, 4'd4, 4'd6, 4'd12, 4'd4, 4'd6, 1'b1, 1'b0, 8, 1'b0, 1'b1, -1, 0);
    play_round("d6_seven", 1'b1, 4'd4, 4'd6, 4'd7, 4'd1, 4'd8, 1'b1, 1'b1, 9, 1'b0, 1'b1, -1, 0);
  endtask

  task automatic test_player_stands();
    play_round("p_stand", 1'b1, 4'd6, 4'd5, 4'd3, 4'd6, 4'd6, 1'b0, 1'b1, 8, 1'b1, 1'b1, -1, 0);
  endtask

  task automatic test_boundaries();
    // Dealer 3 stands only on an eight.
    play_round("d3_eight", 1'b1, 4'd0, 4'd3, 4'd8, 4'd8, 4'd3, 1'b1, 1'b0, 8, 1'b1, 1'b0, -1, 0);
    // Player 5 draws (just below stand), dealer 7 never draws.
    play_round("p5_d7", 1'b1, 4'd5, 4'd7, 4'd2, 4'd7, 4'd7, 1'b1, 1'b0, 8, 1'b1, 1'b1, -1, 0);
    // Out-of-range totals act as 9: natural and tie.
    play_round("oor_tie", 1'b1, 4'd12, 4'd15, 4'd1, 4'd12, 4'd15, 1'b0, 1'b0, 6, 1'b1, 1'b1, -1, 0);
  endtask

  task automatic test_stall();
    play_round("stall_d1", 1'b1, 4'd7, 4'd7, 4'd1, 4'd7, 4'd7, 1'b0, 1'b0, 7, 1'b1, 1'b1, 1, 10);
  endtask

  task automatic test_mid_round_reset();
    logic [5:0] l;
    apply_reset();
    bus.pscore = 4'd2;
    bus.dscore = 4'd4;
    bus.pcard3 = 4'd5;
    for (int i = 0; i < 6; i++) begin
      @(negedge slow_clock);
      bus.step = 1'b1;
      @(posedge slow_clock);
      #1;
    end
    // Now in EVAL_D3; assert reset mid-phase with step still high.
    @(negedge slow_clock);
    #2;
    resetb = 1'b0;
    #1;
    l = loads();
    checks++;
    if (l !== 6'b0 || bus.round_done !== 1'b0 || bus.player_win_light !== 1'b0 ||
        bus.dealer_win_light !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got loads=%b done=%b p=%b d=%b want all 0", l,
               bus.round_done, bus.player_win_light, bus.dealer_win_light);
    end
    bus.step = 1'b0;
    @(negedge slow_clock);
    resetb = 1'b1;
    play_round("after_reset", 1'b0, 4'd2, 4'd4, 4'd5, 4'd7, 4'd1, 1'b1, 1'b1, 9, 1'b1, 1'b0, -1, 0);
  endtask

  task automatic test_done_hold();
    logic [5:0] l;
    play_round("pre_hold", 1'b1, 4'd9, 4'd2, 4'd1, 4'd9, 4'd2, 1'b0, 1'b0, 6, 1'b1, 1'b0, -1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge slow_clock);
      bus.step = 1'b1;
      #1;
      l = loads();
      checks++;
      if (l !== 6'b0 || bus.round_done !== 1'b1 || bus.player_win_light !== 1'b1 ||
          bus.dealer_win_light !== 1'b0) begin
        errors++;
        $display("FAIL done_hold[%0d]: got loads=%b done=%b p=%b d=%b want 000000 1 1 0", i, l,
                 bus.round_done, bus.player_win_light, bus.dealer_win_light);
      end
    end
    #2;
    resetb = 1'b0;
    #1;
    checks++;
    if (bus.round_done !== 1'b0 || bus.player_win_light !== 1'b0) begin
      errors++;
      $display("FAIL done_async_reset: got done=%b p=%b want 0 0", bus.round_done,
               bus.player_win_light);
    end
    bus.step = 1'b0;
    @(negedge slow_clock);
    resetb = 1'b1;
  endtask

  initial begin
    test_reset();
    test_natural();
    test_player_draws();
    test_dealer_six();
    test_player_stands();
    test_boundaries();
    test_stall();
    test_mid_round_reset();
    test_done_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
